// File: rtl/sos_pkg.sv
// Shared types for the speed-of-sound calculator and its delay tracker.
package sos_pkg;

  localparam int unsigned DELAY_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    REQUEST,
    AWAIT_RESULT,
    UPDATE
  } tracker_state_t;

  typedef enum logic [1:0] {
    CALC_IDLE,
    CALC_EMIT,
    CALC_LISTEN,
    CALC_DONE
  } calc_state_t;

  // |a - b| taken through a signed difference one bit wider than the delay.
  function automatic logic [DELAY_W:0] abs_diff(input logic [DELAY_W-1:0] a,
                                                input logic [DELAY_W-1:0] b);
    logic signed [DELAY_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DELAY_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/delay_ring_avg.sv
// Ring buffer of the last NUM_AVG accepted delays with a running sum.
// avg is rewritten only when the buffer is full after a push and is held
// across a flush; wrote pulses for one cycle on each rewrite.
module delay_ring_avg
  import sos_pkg::*;
#(
  parameter int unsigned NUM_AVG = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DELAY_W-1:0] value,
  input  logic               flush,
  output logic               full,
  output logic [DELAY_W-1:0] avg,
  output logic               wrote
);

  localparam int unsigned LOG2  = $clog2(NUM_AVG);
  localparam int unsigned SUM_W = DELAY_W + LOG2;
  localparam int unsigned CNT_W = LOG2 + 1;

  logic [DELAY_W-1:0] ring [NUM_AVG];
  logic [LOG2-1:0]    wr_ptr;
  logic [CNT_W-1:0]   fill;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   sum_next;
  logic               full_next;

  assign full = (fill == CNT_W'(NUM_AVG));

  // Sum after the pending push; the oldest entry leaves only once full.
  always_comb begin
    sum_next  = sum + SUM_W'(value);
    full_next = full || (fill == CNT_W'(NUM_AVG - 1));
    if (full) begin
      sum_next = sum + SUM_W'(value) - SUM_W'(ring[wr_ptr]);
    end
  end

  // Sample storage; contents are only read once every slot has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      ring[wr_ptr] <= value;
    end
  end

  // Pointer, fill level, running sum and published average.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
      avg    <= '0;
      wrote  <= 1'b0;
    end else begin
      wrote <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        fill   <= '0;
        sum    <= '0;
      end else if (push) begin
        wr_ptr <= (wr_ptr == LOG2'(NUM_AVG - 1)) ? '0 : wr_ptr + LOG2'(1);
        sum    <= sum_next;
        if (!full) begin
          fill <= fill + CNT_W'(1);
        end
        if (full_next) begin
          avg   <= DELAY_W'(sum_next >> LOG2);
          wrote <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/delay_tracker.sv
// Paces calculator triggers, captures returned delays, rejects outliers once
// locked and publishes a running average of the accepted delays.
module delay_tracker
  import sos_pkg::*;
#(
  parameter int unsigned NUM_AVG        = 8,
  parameter int unsigned TRIGGER_PERIOD = 2400,
  parameter int unsigned TIMEOUT        = 4800,
  parameter int unsigned MAX_DEV        = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               step_in,
  input  logic               enable_in,
  input  logic [DELAY_W-1:0] delay_in,
  input  logic               delay_valid_in,
  output logic               trigger_out,
  output logic [DELAY_W-1:0] delay_out,
  output logic               delay_valid_out,
  output logic               update_out,
  output logic [7:0]         reject_count_out,
  output logic [7:0]         miss_count_out
);

  localparam int unsigned PER_W = $clog2(TRIGGER_PERIOD + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RUN_W = $clog2(NUM_AVG + 1);
  localparam logic [DELAY_W:0] DEV_LIMIT = (DELAY_W + 1)'(MAX_DEV);

  tracker_state_t     state;
  logic [PER_W-1:0]   period_cnt;
  logic [TMO_W-1:0]   timeout_cnt;
  logic [RUN_W-1:0]   reject_run;
  logic [DELAY_W-1:0] captured;
  logic               valid_prev;
  logic               rise;
  logic               in_update;
  logic               outlier;
  logic               push;
  logic               flush;

  assign rise = delay_valid_in & ~valid_prev;

  // Accept/reject decision for the captured sample while in UPDATE.
  always_comb begin
    in_update = (state == UPDATE) && enable_in;
    outlier   = delay_valid_out && (abs_diff(captured, delay_out) > DEV_LIMIT);
    push      = in_update && !outlier;
    flush     = in_update && outlier && (reject_run == RUN_W'(NUM_AVG - 1));
  end

  // Edge register follows delay_valid_in in every state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_prev <= 1'b0;
    end else begin
      valid_prev <= delay_valid_in;
    end
  end

  // Measurement loop: pacing, request, capture/timeout and outlier counting.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      period_cnt       <= '0;
      timeout_cnt      <= '0;
      captured         <= '0;
      reject_run       <= '0;
      trigger_out      <= 1'b0;
      reject_count_out <= '0;
      miss_count_out   <= '0;
    end else begin
      trigger_out <= 1'b0;
      if (!enable_in) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            period_cnt <= '0;
            state      <= WAIT_PERIOD;
          end
          WAIT_PERIOD: begin
            if (step_in) begin
              if (period_cnt == PER_W'(TRIGGER_PERIOD - 1)) begin
                state <= REQUEST;
              end else begin
                period_cnt <= period_cnt + PER_W'(1);
              end
            end
          end
          REQUEST: begin
            trigger_out <= 1'b1;
            timeout_cnt <= '0;
            state       <= AWAIT_RESULT;
          end
          AWAIT_RESULT: begin
            if (rise) begin
              captured <= delay_in;
              state    <= UPDATE;
            end else if (step_in) begin
              if (timeout_cnt == TMO_W'(TIMEOUT - 1)) begin
                if (miss_count_out != '1) begin
                  miss_count_out <= miss_count_out + 8'd1;
                end
                period_cnt <= '0;
                state      <= WAIT_PERIOD;
              end else begin
                timeout_cnt <= timeout_cnt + TMO_W'(1);
              end
            end
          end
          UPDATE: begin
            if (outlier) begin
              if (reject_count_out != '1) begin
                reject_count_out <= reject_count_out + 8'd1;
              end
              reject_run <= flush ? '0 : reject_run + RUN_W'(1);
            end else begin
              reject_run <= '0;
            end
            period_cnt <= '0;
            state      <= WAIT_PERIOD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  delay_ring_avg #(
    .NUM_AVG(NUM_AVG)
  ) u_ring (
    .clk  (clk_in),
    .rst_n(rst_in),
    .push (push),
    .value(captured),
    .flush(flush),
    .full (delay_valid_out),
    .avg  (delay_out),
    .wrote(update_out)
  );

endmodule

// File: tb/tb_delay_tracker.sv
`timescale 1ns/1ps
module tb_delay_tracker;

  localparam int NAVG   = 4;
  localparam int PER    = 10;
  localparam int TMO    = 20;
  localparam int MAXDEV = 8;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       step   = 1'b1;
  logic       enable = 1'b0;
  logic       dvalid = 1'b0;
  logic [7:0] din    = '0;
  logic       trig, dval_out, upd;
  logic [7:0] dout, rejc, missc;

  delay_tracker #(
    .NUM_AVG(NAVG),
    .TRIGGER_PERIOD(PER),
    .TIMEOUT(TMO),
    .MAX_DEV(MAXDEV)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .step_in(step),
    .enable_in(enable),
    .delay_in(din),
    .delay_valid_in(dvalid),
    .trigger_out(trig),
    .delay_out(dout),
    .delay_valid_out(dval_out),
    .update_out(upd),
    .reject_count_out(rejc),
    .miss_count_out(missc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int at;
    int dout;
    int dval;
    int rej;
    int miss;
  } trig_exp_t;

  trig_exp_t trig_q[$];
  int        upd_q[$];

  // Reference model: the accepted samples themselves, newest last.
  int mq[$];
  int m_out, m_rej, m_miss, m_run;

  function automatic void check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_out  = 0;
    m_rej  = 0;
    m_miss = 0;
    m_run  = 0;
  endfunction

  function automatic void model_capture(int v);
    int d;
    int s;
    d = v - m_out;
    if (d < 0) d = -d;
    if (mq.size() == NAVG && d > MAXDEV) begin
      if (m_rej < 255) m_rej++;
      m_run++;
      if (m_run == NAVG) begin
        mq.delete();
        m_run = 0;
      end
    end else begin
      m_run = 0;
      mq.push_back(v);
      if (mq.size() > NAVG) mq.delete(0);
      if (mq.size() == NAVG) begin
        s = 0;
        foreach (mq[i]) s += mq[i];
        m_out = s / NAVG;
        upd_q.push_back(m_out);
      end
    end
  endfunction

  function automatic void model_miss();
    if (m_miss < 255) m_miss++;
  endfunction

  // w is the edge on which the period count starts from zero.
  function automatic void push_trig(int w);
    trig_exp_t e;
    e.at   = w + PER + 1;
    e.dout = m_out;
    e.dval = (mq.size() == NAVG) ? 1 : 0;
    e.rej  = m_rej;
    e.miss = m_miss;
    trig_q.push_back(e);
  endfunction

  // Monitor: compares DUT events against the scoreboard queues.
  trig_exp_t mon_e;
  int        mon_u;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (trig) begin
        if (trig_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL trigger_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_e = trig_q.pop_front();
          check("trigger_cycle", cyc, mon_e.at);
          check("trig_delay_out", int'(dout), mon_e.dout);
          check("trig_delay_valid", int'(dval_out), mon_e.dval);
          check("trig_reject_count", int'(rejc), mon_e.rej);
          check("trig_miss_count", int'(missc), mon_e.miss);
        end
      end
      if (upd) begin
        if (upd_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL update_unexpected: got pulse with delay_out %0d at cycle %0d, required none", dout, cyc);
        end else begin
          mon_u = upd_q.pop_front();
          check("update_delay_out", int'(dout), mon_u);
          check("update_delay_valid", int'(dval_out), 1);
        end
      end
    end
  end

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic wait_trigger(output int t);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!trig && n < 200);
    if (!trig) begin
      compared++;
      mismatched++;
      $display("FAIL trigger_wait: no pulse within 200 cycles, required one");
      finish_run();
    end
    t = cyc;
  endtask

  // k = 0: no response; otherwise raise delay_valid_in k cycles after the trigger.
  task automatic transact(input int v, input int k, input bit lower);
    int t;
    logic [7:0] vb;
    wait_trigger(t);
    if (lower) dvalid = 1'b0;
    if (k == 0) begin
      model_miss();
      push_trig(t + TMO);
    end else begin
      repeat (k) @(posedge clk);
      #1;
      vb     = v[7:0];
      din    = vb;
      dvalid = 1'b1;
      if (k <= TMO - 1) begin
        model_capture(v);
        push_trig(t + k + 2);
      end else begin
        model_miss();
        push_trig(t + TMO);
      end
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_trigger"}, int'(trig), 0);
    check({tag, "_delay_out"}, int'(dout), 0);
    check({tag, "_delay_valid"}, int'(dval_out), 0);
    check({tag, "_update"}, int'(upd), 0);
    check({tag, "_reject_count"}, int'(rejc), 0);
    check({tag, "_miss_count"}, int'(missc), 0);
  endtask

  initial begin
    int t, v, k, r;
    model_reset();
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    push_trig(cyc + 1);

    // Fill: 40,42,44,46 -> 43 after the fourth
    transact(40, 3, 1);
    transact(42, 5, 1);
    transact(44, 1, 1);
    transact(46, 19, 1);

    // Lock at 40, reject 100, accept 48 at exactly MAX_DEV
    for (int i = 0; i < 4; i++) transact(40, int'($urandom_range(1, 19)), 1);
    transact(100, 4, 1);
    transact(48, 6, 1);

    // Relock at 40, four rejects flush, four more refill at 100
    for (int i = 0; i < 4; i++) transact(40, int'($urandom_range(1, 19)), 1);
    for (int i = 0; i < 4; i++) transact(100, int'($urandom_range(1, 19)), 1);
    for (int i = 0; i < 4; i++) transact(100, int'($urandom_range(1, 19)), 1);

    // Timeout, edge on the timeout cycle, edge one cycle too late
    transact(0, 0, 1);
    transact(104, TMO - 1, 1);
    transact(101, TMO, 1);

    // enable_in dropped mid-wait: back to IDLE, loop restarts on re-enable
    wait_trigger(t);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;
    push_trig(cyc + 1);

    // Randomized traffic around the current average
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (mq.size() == NAVG && r < 7) begin
        v = m_out - 12 + int'($urandom_range(0, 24));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end else begin
        v = int'($urandom_range(0, 255));
      end
      if (r == 9) k = (i % 2 == 1) ? 0 : int'($urandom_range(TMO, TMO + 4));
      else        k = int'($urandom_range(1, TMO - 1));
      transact(v, k, 1);
    end

    // Miss counter saturation
    for (int i = 0; i < 258; i++) transact(0, 0, 1);

    // Reset during AWAIT_RESULT with delay_valid_in held high
    transact(60, 2, 1);
    wait_trigger(t);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("midreset");
    model_reset();
    rst = 1'b1;
    push_trig(cyc + 1);
    transact(0, 0, 0);
    transact(50, 3, 1);

    r = 0;
    while (trig_q.size() != 0 && r < 100) begin
      @(posedge clk);
      #2;
      r++;
    end
    check("trig_queue_drained", trig_q.size(), 0);
    check("update_queue_drained", upd_q.size(), 0);
    finish_run();
  end

endmodule
